// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit sequential adder that streams LSB-first operand bits
// through a single full-adder cell (two half-adder steps) with a registered carry.
// An operation is accepted with start, runs WIDTH cycles with busy high, then
// pulses done for one cycle with sum/carry_out valid; results hold until the
// next completion.
//
// Optional feature macro: BIT_SERIAL_SUB_EN adds the sub port (1 = A-B). When
// subtracting, B is inverted into the adder and the initial carry is 1.
// carry_out is then the no-borrow flag.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request an operation; sampled when not busy
//   op_a       in   WIDTH  operand A, captured on the accepting edge
//   op_b       in   WIDTH  operand B, captured on the accepting edge
//   sub        in   1      subtract select (only with BIT_SERIAL_SUB_EN)
//   busy       out  1      operation in progress
//   done       out  1      one-cycle result-valid pulse
//   sum        out  WIDTH  result, held until the next completion
//   carry_out  out  1      final carry / no-borrow, held with sum
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, a_sr_d;
    logic [WIDTH-1:0] b_sr, b_sr_d;
    logic [WIDTH-1:0] partial, partial_d;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    count, count_d;
    logic             carry, carry_d;
    logic             cout_d, busy_d, done_d;

    // Operand B and initial carry as loaded on accept
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef BIT_SERIAL_SUB_EN
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub;
`else
    assign b_load = op_b;
    assign c_load = 1'b0;
`endif

    // Full adder as two cascaded half adders
    logic hs1, hc1, fa_s, fa_c;
    assign hs1  = a_sr[0] ^ b_sr[0];
    assign hc1  = a_sr[0] & b_sr[0];
    assign fa_s = hs1 ^ carry;
    assign fa_c = hc1 | (hs1 & carry);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            partial   <= '0;
            count     <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            a_sr      <= a_sr_d;
            b_sr      <= b_sr_d;
            partial   <= partial_d;
            count     <= count_d;
            carry     <= carry_d;
            sum       <= sum_d;
            carry_out <= cout_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        a_sr_d    = a_sr;
        b_sr_d    = b_sr;
        partial_d = partial;
        count_d   = count;
        carry_d   = carry;
        sum_d     = sum;
        cout_d    = carry_out;
        busy_d    = busy;
        done_d    = 1'b0;

        case (state)
            // DONE's exit edge may accept a new op so throughput is one per WIDTH+1
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d   = S_ADD;
                    a_sr_d    = op_a;
                    b_sr_d    = b_load;
                    carry_d   = c_load;
                    count_d   = '0;
                    partial_d = '0;
                    busy_d    = 1'b1;
                end
            end

            S_ADD: begin
                a_sr_d    = {1'b0, a_sr[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr[WIDTH-1:1]};
                partial_d = {fa_s, partial[WIDTH-1:1]};
                carry_d   = fa_c;
                count_d   = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = {fa_s, partial[WIDTH-1:1]};
                    cout_d  = fa_c;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
